// File: rtl/ucsbece154a_mc_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, ALUOp,
// datapath mux selects, opcodes and ALU/immediate codes.
package ucsbece154a_mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    JALRADR  = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Only add/sub, slt, or, and are implemented for R-type and I-ALU.
  function automatic logic aluFunct3Legal(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: aluFunct3Legal = 1'b1;
      default:                        aluFunct3Legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ucsbece154a_mc_controller_aludec.sv
// ALU decoder: maps the internal ALUOp plus instruction fields onto the
// ALU operation code.
module ucsbece154a_aludec
  import ucsbece154a_mc_controller_pkg::*;
(
  input  logic [1:0] ALUOp_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] ALUControl_o
);

  always_comb begin
    ALUControl_o = ALU_ADD;
    case (ALUOp_i)
      ALUOP_ADD: ALUControl_o = ALU_ADD;
      ALUOP_SUB: ALUControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) can encode sub; addi ignores funct7.
          3'b000:  ALUControl_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl_o = ALU_SLT;
          3'b110:  ALUControl_o = ALU_OR;
          3'b111:  ALUControl_o = ALU_AND;
          default: ALUControl_o = ALU_ADD;
        endcase
      end
      default: ALUControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM over fetch/decode/execute/memory/
// writeback with optional memory-ready stalls and a sticky illegal trap.
module ucsbece154a_mc_controller
  import ucsbece154a_mc_controller_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       IRWrite_o,
  output logic       MemWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic       ready;
  logic       pcUpdate, branch, irWrite, memWrite, regWrite;
  logic [1:0] aluOp;

  assign ready = mem_ready_i | ~MEM_HANDSHAKE;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWrite     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        irWrite     = ready;
        pcUpdate    = ready;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        case (op_i)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = aluFunct3Legal(funct3_i) ? EXECR : ILLEGAL;
          OP_ITYPE:     state_d = aluFunct3Legal(funct3_i) ? EXECI : ILLEGAL;
          OP_BRANCH:    state_d = (funct3_i == FUNCT3_BEQ || funct3_i == FUNCT3_BNE)
                                  ? BRANCH : ILLEGAL;
          OP_JAL:       state_d = JAL;
          OP_JALR:      state_d = JALRADR;
          OP_LUI:       state_d = LUI;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (op_i == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc_o = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc_o = RES_DATA;
        regWrite    = 1'b1;
        state_d     = FETCH;
      end
      MEMWRITE: begin
        AdrSrc_o = 1'b1;
        memWrite = 1'b1;
        if (ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA_o = SRCA_RS1;
        aluOp     = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        regWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA_o = SRCA_RS1;
        aluOp     = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      // jalr computes rs1+imm into ALUOut, then reuses JAL to jump and link.
      JALRADR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = JAL;
      end
      JAL: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        pcUpdate  = 1'b1;
        state_d   = ALUWB;
      end
      LUI: begin
        ResultSrc_o = RES_IMMEXT;
        regWrite    = 1'b1;
        state_d     = FETCH;
      end
      ILLEGAL: state_d = ILLEGAL;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    case (op_i)
      OP_SW:     ImmSrc_o = IMM_S;
      OP_BRANCH: ImmSrc_o = IMM_B;
      OP_JAL:    ImmSrc_o = IMM_J;
      OP_LUI:    ImmSrc_o = IMM_U;
      default:   ImmSrc_o = IMM_I;
    endcase
  end

  ucsbece154a_aludec u_aludec (
    .ALUOp_i      (aluOp),
    .funct3_i     (funct3_i),
    .op5_i        (op_i[5]),
    .funct7b5_i   (funct7b5_i),
    .ALUControl_o (ALUControl_o)
  );

  // Funct3 bit 0 distinguishes bne from beq, inverting the zero condition.
  assign PCWrite_o  = ~reset & (pcUpdate | (branch & (zero_i ^ funct3_i[0])));
  assign IRWrite_o  = ~reset & irWrite;
  assign MemWrite_o = ~reset & memWrite;
  assign RegWrite_o = ~reset & regWrite;
  assign illegal_o  = (state_q == ILLEGAL);
  assign state_o    = state_q;

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Directed self-checking bench for the multicycle controller, with a second
// instance built without the memory handshake.
module tb_ucsbece154a_mc_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11,
                         S_JALRADR = 4'd12, S_ILLEGAL = 4'd13;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, memReady;

  logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, immSrc;
  logic [3:0] state;

  logic       h0PcWrite, h0AdrSrc, h0IrWrite, h0MemWrite, h0RegWrite, h0Illegal;
  logic [1:0] h0ResultSrc, h0AluSrcA, h0AluSrcB;
  logic [2:0] h0AluControl, h0ImmSrc;
  logic [3:0] h0State;

  int checks = 0;
  int failures = 0;
  int memwCount = 0;

  always #5 clk = ~clk;

  ucsbece154a_mc_controller dut (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(memReady), .PCWrite_o(pcWrite), .AdrSrc_o(adrSrc),
    .IRWrite_o(irWrite), .MemWrite_o(memWrite), .RegWrite_o(regWrite),
    .ResultSrc_o(resultSrc), .ALUSrcA_o(aluSrcA), .ALUSrcB_o(aluSrcB),
    .ALUControl_o(aluControl), .ImmSrc_o(immSrc), .illegal_o(illegal), .state_o(state)
  );

  ucsbece154a_mc_controller #(.MEM_HANDSHAKE(1'b0)) dutNoHs (
    .clk(clk), .reset(reset2), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(memReady), .PCWrite_o(h0PcWrite), .AdrSrc_o(h0AdrSrc),
    .IRWrite_o(h0IrWrite), .MemWrite_o(h0MemWrite), .RegWrite_o(h0RegWrite),
    .ResultSrc_o(h0ResultSrc), .ALUSrcA_o(h0AluSrcA), .ALUSrcB_o(h0AluSrcB),
    .ALUControl_o(h0AluControl), .ImmSrc_o(h0ImmSrc), .illegal_o(h0Illegal), .state_o(h0State)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; memReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] st, input logic pcw,
                            input logic irw, input logic regw, input logic memw);
    checkOutput({tag, ".state"}, state, st);
    checkOutput({tag, ".PCWrite"}, pcWrite, pcw);
    checkOutput({tag, ".IRWrite"}, irWrite, irw);
    checkOutput({tag, ".RegWrite"}, regWrite, regw);
    checkOutput({tag, ".MemWrite"}, memWrite, memw);
    if (memWrite === 1'b1) memwCount++;
  endtask

  initial begin
    logic [3:0] noHsStates [4];
    noHsStates = '{S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};

    reset = 1'b1; reset2 = 1'b1;
    applyStimulus(LW, 3'b010, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkCycle("rst", S_FETCH, 0, 0, 0, 0);
    checkOutput("rst.illegal", illegal, 0);
    checkOutput("rst.ALUSrcB", aluSrcB, 2'b10);
    checkOutput("rst.ResultSrc", resultSrc, 2'b10);
    reset = 1'b0; #1;

    // lw: five cycles, fetch enables only in cycle 1
    checkCycle("lw.c1", S_FETCH, 1, 1, 0, 0);
    checkOutput("lw.c1.AdrSrc", adrSrc, 0);
    tick(); checkCycle("lw.c2", S_DECODE, 0, 0, 0, 0);
    checkOutput("lw.c2.ALUSrcA", aluSrcA, 2'b01);
    checkOutput("lw.c2.ALUSrcB", aluSrcB, 2'b01);
    tick(); checkCycle("lw.c3", S_MEMADR, 0, 0, 0, 0);
    checkOutput("lw.c3.ALUSrcA", aluSrcA, 2'b10);
    tick(); checkCycle("lw.c4", S_MEMREAD, 0, 0, 0, 0);
    checkOutput("lw.c4.AdrSrc", adrSrc, 1);
    tick(); checkCycle("lw.c5", S_MEMWB, 0, 0, 1, 0);
    checkOutput("lw.c5.ResultSrc", resultSrc, 2'b01);
    tick(); checkCycle("lw.done", S_FETCH, 1, 1, 0, 0);

    // R-type sub, R-type and, addi with funct7b5 set
    applyStimulus(RT, 3'b000, 1'b1, 1'b0, 1'b1);
    tick(); tick(); checkCycle("sub.exec", S_EXECR, 0, 0, 0, 0);
    checkOutput("sub.ALUControl", aluControl, 3'b001);
    checkOutput("sub.ALUSrcB", aluSrcB, 2'b00);
    tick(); checkCycle("sub.wb", S_ALUWB, 0, 0, 1, 0);
    tick(); checkOutput("sub.done", state, S_FETCH);
    applyStimulus(RT, 3'b111, 1'b0, 1'b0, 1'b1);
    tick(); tick(); checkOutput("and.state", state, S_EXECR);
    checkOutput("and.ALUControl", aluControl, 3'b100);
    tick(); tick(); checkOutput("and.done", state, S_FETCH);
    applyStimulus(IT, 3'b000, 1'b1, 1'b0, 1'b1);
    tick(); tick(); checkOutput("addi.state", state, S_EXECI);
    checkOutput("addi.ALUControl", aluControl, 3'b000);
    checkOutput("addi.ALUSrcB", aluSrcB, 2'b01);
    tick(); tick(); checkOutput("addi.done", state, S_FETCH);

    // bne and beq, zero_i toggled within BRANCH
    applyStimulus(BR, 3'b001, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("bne.ImmSrc", immSrc, 3'b010);
    tick(); checkCycle("bne.z0", S_BRANCH, 1, 0, 0, 0);
    checkOutput("bne.ALUControl", aluControl, 3'b001);
    zero = 1'b1; #1; checkOutput("bne.z1.PCWrite", pcWrite, 0);
    tick(); checkOutput("bne.done", state, S_FETCH);
    applyStimulus(BR, 3'b000, 1'b0, 1'b1, 1'b1);
    tick(); tick(); checkCycle("beq.z1", S_BRANCH, 1, 0, 0, 0);
    zero = 1'b0; #1; checkOutput("beq.z0.PCWrite", pcWrite, 0);
    tick(); checkOutput("beq.done", state, S_FETCH);

    // jalr, jal, lui
    applyStimulus(JR, 3'b000, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("jalr.ImmSrc", immSrc, 3'b000);
    tick(); checkCycle("jalr.adr", S_JALRADR, 0, 0, 0, 0);
    checkOutput("jalr.adr.ALUSrcA", aluSrcA, 2'b10);
    checkOutput("jalr.adr.ALUSrcB", aluSrcB, 2'b01);
    tick(); checkCycle("jalr.jal", S_JAL, 1, 0, 0, 0);
    checkOutput("jalr.jal.ALUSrcA", aluSrcA, 2'b01);
    checkOutput("jalr.jal.ALUSrcB", aluSrcB, 2'b10);
    tick(); checkCycle("jalr.wb", S_ALUWB, 0, 0, 1, 0);
    tick(); checkOutput("jalr.done", state, S_FETCH);
    applyStimulus(JL, 3'b000, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("jal.ImmSrc", immSrc, 3'b011);
    tick(); checkCycle("jal.jal", S_JAL, 1, 0, 0, 0);
    tick(); checkCycle("jal.wb", S_ALUWB, 0, 0, 1, 0);
    tick(); checkOutput("jal.done", state, S_FETCH);
    applyStimulus(LU, 3'b000, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("lui.ImmSrc", immSrc, 3'b100);
    tick(); checkCycle("lui.wb", S_LUI, 0, 0, 1, 0);
    checkOutput("lui.ResultSrc", resultSrc, 2'b11);
    tick(); checkOutput("lui.done", state, S_FETCH);

    // sw with three not-ready cycles in MEMWRITE
    applyStimulus(SW, 3'b010, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("sw.ImmSrc", immSrc, 3'b001);
    tick(); checkOutput("sw.memadr", state, S_MEMADR);
    memReady = 1'b0;
    memwCount = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); checkCycle("sw.stall", S_MEMWRITE, 0, 0, 0, 1);
    end
    memReady = 1'b1; #1;
    checkCycle("sw.ready", S_MEMWRITE, 0, 0, 0, 1);
    checkOutput("sw.AdrSrc", adrSrc, 1);
    tick(); checkCycle("sw.done", S_FETCH, 1, 1, 0, 0);
    checkOutput("sw.memwCycles", memwCount, 4);

    // Fetch stall on the handshake instance; no-handshake instance runs lw
    applyStimulus(LW, 3'b010, 1'b0, 1'b0, 1'b0);
    reset2 = 1'b0; #1;
    checkCycle("fstall.c0", S_FETCH, 0, 0, 0, 0);
    checkOutput("nohs.c0.IRWrite", h0IrWrite, 1);
    checkOutput("nohs.c0.PCWrite", h0PcWrite, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCycle("fstall", S_FETCH, 0, 0, 0, 0);
      checkOutput("nohs.state", h0State, noHsStates[i]);
    end
    checkOutput("nohs.wb.RegWrite", h0RegWrite, 1);
    reset2 = 1'b1;
    memReady = 1'b1; #1;
    checkCycle("fstall.release", S_FETCH, 1, 1, 0, 0);

    // R-type with unsupported funct3 traps; reset recovers
    applyStimulus(RT, 3'b001, 1'b0, 1'b0, 1'b1);
    tick(); tick(); checkCycle("sll.trap", S_ILLEGAL, 0, 0, 0, 0);
    checkOutput("sll.illegal", illegal, 1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checkCycle("sll.rst", S_FETCH, 1, 1, 0, 0);

    // Unknown opcode: sticky trap for 10 cycles, then one-cycle reset
    applyStimulus(BAD, 3'b000, 1'b0, 1'b0, 1'b1);
    tick(); tick(); checkOutput("bad.illegal", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkCycle("bad.hold", S_ILLEGAL, 0, 0, 0, 0);
      checkOutput("bad.hold.illegal", illegal, 1);
    end
    reset = 1'b1; tick();
    checkCycle("bad.inreset", S_FETCH, 0, 0, 0, 0);
    reset = 1'b0; #1;
    checkCycle("bad.rst", S_FETCH, 1, 1, 0, 0);
    checkOutput("bad.rst.illegal", illegal, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
